// File: rtl/snitch_mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between NumReq requesters.
// Read ownership is tracked in an ID FIFO so in-order responses return to their issuer.
module snitch_mem_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq-1:0]             req_wstrb_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq*DataWidth-1:0]   rsp_data_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [AddrWidth-1:0]          mem_req_addr_o,
    output logic [DataWidth-1:0]          mem_req_data_o,
    output logic                          mem_req_write_o,
    output logic                          mem_req_wstrb_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    input  logic [DataWidth-1:0]          mem_rsp_data_i,
    input  logic                          mem_rsp_valid_i,
    output logic                          mem_rsp_ready_o,
    output logic                          err_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_found;
    logic [NumReq-1:0] eligible;
    logic [NumReq-1:0] gnt;

    logic [IdxW-1:0]   fifo_q [MaxOutstanding];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IdxW-1:0]   owner;

    logic              handshake;
    logic              push;
    logic              pop;
    logic              err_q;

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign eligible   = req_valid_i & (req_write_i | {NumReq{~fifo_full}});

    // Two passes give round-robin order: indices at/after ptr first, then the wrap-around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!gnt_found && eligible[i] && (i >= 32'(ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(i);
            end
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!gnt_found && eligible[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(i);
            end
        end
        gnt = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            gnt[i] = gnt_found && (gnt_idx == IdxW'(i));
        end
    end

    always_comb begin
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        mem_req_write_o = 1'b0;
        mem_req_wstrb_o = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                mem_req_addr_o  = req_addr_i[i*AddrWidth +: AddrWidth];
                mem_req_data_o  = req_data_i[i*DataWidth +: DataWidth];
                mem_req_write_o = req_write_i[i];
                mem_req_wstrb_o = req_wstrb_i[i];
            end
        end
    end

    assign mem_req_valid_o = |eligible;
    assign req_ready_o     = gnt & {NumReq{mem_req_ready_i}};
    assign handshake       = mem_req_valid_o && mem_req_ready_i;
    assign push            = handshake && !mem_req_write_o;

    assign owner      = fifo_q[rd_ptr_q];
    assign rsp_data_o = {NumReq{mem_rsp_data_i}};

    // With no read outstanding, any response is drained so the memory cannot lock up.
    always_comb begin
        rsp_valid_o     = '0;
        mem_rsp_ready_o = mem_rsp_valid_i;
        if (!fifo_empty) begin
            mem_rsp_ready_o = 1'b0;
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (owner == IdxW'(i)) begin
                    rsp_valid_o[i]  = mem_rsp_valid_i;
                    mem_rsp_ready_o = rsp_ready_i[i];
                end
            end
        end
    end

    assign pop   = mem_rsp_valid_i && mem_rsp_ready_o && !fifo_empty;
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                ptr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= (MaxOutstanding == 1) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (MaxOutstanding == 1) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (mem_rsp_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_snitch_mem_arbiter.sv
// Scoreboard bench for snitch_mem_arbiter: directed requester traffic against a
// one-cycle-latency memory model, with per-port expected-response queues.
module tb_snitch_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_write;
    logic [1:0]  req_wstrb;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [9:0]  mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_req_write;
    logic        mem_req_wstrb;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic        err;

    logic        mdl_valid;
    logic [31:0] mdl_data;
    logic        spur;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] mq      [$];
    logic [31:0] exp_q   [2][$];
    logic [31:0] mon_exp;

    int checks = 0;
    int errors = 0;
    int n0;
    int n1;

    assign mem_rsp_valid = mdl_valid | spur;
    assign mem_rsp_data  = spur ? 32'hBAD0_BAD0 : mdl_data;

    snitch_mem_arbiter #(
        .NumReq         (2),
        .AddrWidth      (10),
        .DataWidth      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_write_i     (req_write),
        .req_wstrb_i     (req_wstrb),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .rsp_data_o      (rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_data_o  (mem_req_data),
        .mem_req_write_o (mem_req_write),
        .mem_req_wstrb_o (mem_req_wstrb),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_ready_o (mem_rsp_ready),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drv(input int i, input logic v, input logic w, input logic [9:0] a,
                       input logic [31:0] d);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_wstrb[i]         = w;
        req_addr[i*10 +: 10] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic idle(input int n);
        drv(0, 1'b0, 1'b0, 10'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (n) @(negedge clk);
    endtask

    // Memory model and requester-side issue tracking; drives at negedge, samples 1ns before posedge.
    always begin
        @(negedge clk);
        mdl_valid = (mq.size() > 0);
        mdl_data  = mdl_valid ? mq[0] : 32'h0;
        #4;
        if (!rst_n) begin
            mq.delete();
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_write[i]) begin
                        if (req_wstrb[i]) ref_mem[req_addr[i*10 +: 10]] = req_data[i*32 +: 32];
                    end else begin
                        exp_q[i].push_back(ref_mem[req_addr[i*10 +: 10]]);
                    end
                end
            end
            if (mdl_valid && mem_rsp_ready) void'(mq.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_write) begin
                    if (mem_req_wstrb) mem[mem_req_addr] = mem_req_data;
                end else begin
                    mq.push_back(mem[mem_req_addr]);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected port %0d: got data %h required no response",
                                 i, rsp_data[i*32 +: 32]);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        check($sformatf("rsp_port%0d", i), 64'(rsp_data[i*32 +: 32]), 64'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_wstrb = '0; req_addr = '0; req_data = '0;
        rsp_ready = 2'b11; mem_req_ready = 1'b1; spur = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            mem[a]     = 32'hC0DE_0000 | 32'(a);
            ref_mem[a] = 32'hC0DE_0000 | 32'(a);
        end
        mem[16]     = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst_err", err, 0);

        // Contention: both requesters stream reads, each advancing on acceptance
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drv(0, 1'b1, 1'b0, 10'(10'h100 + n0), 32'h0);
            drv(1, 1'b1, 1'b0, 10'(10'h200 + n1), 32'h0);
            #4;
            check("rr_gnt", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (req_ready[0]) n0++;
            if (req_ready[1]) n1++;
        end
        @(negedge clk);
        idle(3);
        check("rr_count0", n0, 4);
        check("rr_count1", n1, 4);

        // Full FIFO: req0 stalled on response side, third read blocked, write still passes
        rsp_ready = 2'b10;
        drv(0, 1'b1, 1'b0, 10'h020, 32'h0); #4;
        check("full_a", req_ready, 2'b01);
        @(negedge clk); drv(0, 1'b1, 1'b0, 10'h021, 32'h0); #4;
        check("full_b", req_ready, 2'b01);
        @(negedge clk); drv(0, 1'b1, 1'b0, 10'h022, 32'h0); drv(1, 1'b1, 1'b1, 10'h040, 32'h1234_5678); #4;
        check("full_wr_ok", req_ready, 2'b10);
        check("full_wr_addr", mem_req_addr, 10'h040);
        @(negedge clk); drv(1, 1'b0, 1'b0, 10'h0, 32'h0); #4;
        check("full_stall", req_ready, 2'b00);
        check("full_rspv", rsp_valid, 2'b01);
        check("full_mem_rsp_ready", mem_rsp_ready, 0);
        @(negedge clk); rsp_ready = 2'b11; #4;
        check("full_pop_cycle", req_ready, 2'b00);
        check("full_pop_ready", mem_rsp_ready, 1);
        @(negedge clk); #4;
        check("full_resume", req_ready, 2'b01);
        @(negedge clk);
        idle(3);
        check("full_wr_mem", mem[10'h040], 32'h1234_5678);

        // Single read, no contention
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0); #4;
        check("rd_ready", req_ready, 2'b01);
        check("rd_addr", mem_req_addr, 10'h010);
        @(negedge clk); drv(0, 1'b0, 1'b0, 10'h0, 32'h0); #4;
        check("rd_rspv", rsp_valid, 2'b01);
        check("rd_data", rsp_data[31:0], 32'hDEAD_BEEF);
        @(negedge clk); #4;
        check("rd_empty_ready", mem_rsp_ready, 0);
        check("rd_rspv_clear", rsp_valid, 2'b00);

        // Write then read on requester 1
        @(negedge clk); drv(1, 1'b1, 1'b1, 10'h042, 32'h0000_0007); #4;
        check("wr_ready", req_ready, 2'b10);
        check("wr_is_write", mem_req_write, 1);
        @(negedge clk); drv(1, 1'b1, 1'b0, 10'h042, 32'h0); #4;
        check("wr_no_rsp", rsp_valid, 2'b00);
        check("rd42_ready", req_ready, 2'b10);
        @(negedge clk); drv(1, 1'b0, 1'b0, 10'h0, 32'h0); #4;
        check("rd42_rspv", rsp_valid, 2'b10);
        check("rd42_data", rsp_data[63:32], 32'h0000_0007);
        @(negedge clk);
        idle(1);

        // Response backpressure held for three cycles
        rsp_ready = 2'b10;
        drv(0, 1'b1, 1'b0, 10'h030, 32'h0); #4;
        @(negedge clk); drv(0, 1'b0, 1'b0, 10'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #4;
            check("bp_rspv", rsp_valid, 2'b01);
            check("bp_mem_ready", mem_rsp_ready, 0);
            check("bp_data", rsp_data[31:0], 32'hC0DE_0030);
        end
        @(negedge clk); rsp_ready = 2'b11; #4;
        check("bp_release_ready", mem_rsp_ready, 1);
        @(negedge clk); #4;
        check("bp_popped", rsp_valid, 2'b00);
        @(negedge clk);

        // Spurious response, then reset with one read in flight
        spur = 1'b1; #4;
        check("spur_ready", mem_rsp_ready, 1);
        check("spur_rspv", rsp_valid, 2'b00);
        check("spur_err_pre", err, 0);
        @(negedge clk); spur = 1'b0; #4;
        check("spur_err", err, 1);
        @(negedge clk); #4;
        check("spur_err_sticky", err, 1);
        @(negedge clk); drv(0, 1'b1, 1'b0, 10'h050, 32'h0); #4;
        check("inflight_ready", req_ready, 2'b01);
        @(negedge clk); drv(0, 1'b0, 1'b0, 10'h0, 32'h0); rst_n = 1'b0; #4;
        check("rst2_err", err, 0);
        check("rst2_rspv", rsp_valid, 2'b00);
        @(negedge clk); rst_n = 1'b1; #4;
        check("rst2_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst2_err_after", err, 0);
        rsp_ready = 2'b00;
        @(negedge clk); drv(0, 1'b1, 1'b0, 10'h060, 32'h0); drv(1, 1'b1, 1'b0, 10'h061, 32'h0); #4;
        check("rst2_ptr", req_ready, 2'b01);
        @(negedge clk); drv(0, 1'b0, 1'b0, 10'h0, 32'h0); #4;
        check("rst2_fifo_room", req_ready, 2'b10);
        check("rst2_head", rsp_valid, 2'b01);
        @(negedge clk); rsp_ready = 2'b11;
        idle(4);
        #1;
        check("sb_drained0", exp_q[0].size(), 0);
        check("sb_drained1", exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
